// File: rtl/apb_completer_regs_if.sv
// APB4 bus bundle between a requester and the apb_completer_regs register bank.
// clk and reset stay outside the bundle.
interface apb_completer_regs_if #(
   parameter int dataWidth = 32,
   parameter int addrWidth = 32
);
   logic                     pselx;
   logic                     penable;
   logic                     pwrite;
   logic [2:0]               pprot;
   logic [dataWidth/8-1:0]   pstrb;
   logic [addrWidth-1:0]     paddr;
   logic [dataWidth-1:0]     pwdata;
   logic                     pready;
   logic                     pslverr;
   logic [dataWidth-1:0]     prdata;

   modport master (
      output pselx, penable, pwrite, pprot, pstrb, paddr, pwdata,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  pselx, penable, pwrite, pprot, pstrb, paddr, pwdata,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/apb_completer_regs.sv
// APB4 completer with a memory-mapped register bank, programmable wait states,
// PSLVERR on illegal accesses, and per-register write pulses.
module apb_completer_regs #(
   parameter int          dataWidth   = 32,
   parameter int          addrWidth   = 32,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA9B4_0001
) (
   input  logic                          clk,
   input  logic                          rst,
   apb_completer_regs_if.slave           bus,
   output logic [NUM_REGS*dataWidth-1:0] regs_o,
   output logic [NUM_REGS-1:0]           wr_pulse_o
);

   localparam int NBYTES = dataWidth / 8;
   localparam int OFFS   = $clog2(NBYTES);

   typedef enum logic {IDLE, ACCESS} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   cap;
   logic                   done;
   logic                   wr_en;
   logic                   err;
   logic [addrWidth-1:0]   idx;
   logic [dataWidth-1:0]   rdata;

   logic [addrWidth-1:0]   addr_q;
   logic                   write_q;
   logic                   priv_q;
   logic [NBYTES-1:0]      strb_q;
   logic [dataWidth-1:0]   wdata_q;
   logic [dataWidth-1:0]   regs_q [1:NUM_REGS-1];
   logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;

   logic                   unused_prot;
   assign unused_prot = ^bus.pprot[2:1];

   function automatic logic [dataWidth-1:0] merge_bytes(
      input logic [dataWidth-1:0] old_v,
      input logic [dataWidth-1:0] new_v,
      input logic [NBYTES-1:0]    strb
   );
      logic [dataWidth-1:0] res;
      res = old_v;
      for (int b = 0; b < NBYTES; b++)
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      return res;
   endfunction

   // Decode of the transfer captured at setup; the live bus is not consulted here.
   always_comb begin
      idx = addr_q >> OFFS;
      err = (|addr_q[OFFS-1:0])
         || (idx >= addrWidth'(NUM_REGS))
         || (write_q && idx == '0)
         || (write_q && !priv_q && idx >= addrWidth'(NUM_REGS/2));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.pselx && !bus.penable) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_CYCLES);
               cap     = 1'b1;
            end
         end
         ACCESS: begin
            if (!bus.pselx) begin
               state_d = IDLE;
            end else if (bus.penable) begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_en = done && write_q && !err;

   always_comb begin
      rdata = dataWidth'(ID_VALUE);
      for (int i = 1; i < NUM_REGS; i++)
         if (idx == addrWidth'(i)) rdata = regs_q[i];
      bus.pready  = done;
      bus.pslverr = done && err;
      bus.prdata  = (done && !write_q && !err) ? rdata : '0;
      wr_pulse_d  = '0;
      for (int i = 1; i < NUM_REGS; i++)
         if (wr_en && idx == addrWidth'(i)) wr_pulse_d[i] = 1'b1;
   end

   always_comb begin
      regs_o = '0;
      regs_o[dataWidth-1:0] = dataWidth'(ID_VALUE);
      for (int i = 1; i < NUM_REGS; i++)
         regs_o[i*dataWidth +: dataWidth] = regs_q[i];
   end

   assign wr_pulse_o = wr_pulse_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         wr_pulse_q <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         priv_q     <= 1'b0;
         strb_q     <= '0;
         wdata_q    <= '0;
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_pulse_q <= wr_pulse_d;
         if (cap) begin
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            priv_q  <= bus.pprot[0];
            strb_q  <= bus.pstrb;
            wdata_q <= bus.pwdata;
         end
         for (int i = 1; i < NUM_REGS; i++)
            if (wr_en && idx == addrWidth'(i))
               regs_q[i] <= merge_bytes(regs_q[i], wdata_q, strb_q);
      end
   end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: one instance with one wait state, one with none,
// a directed vector table, hand-built abort/reset sequences and a random run.
module tb_apb_completer_regs;

   localparam logic [31:0] ID = 32'hA9B4_0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst0;
   logic [1:0]  psel;
   logic        penable, pwrite;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;
   logic [31:0] paddr, pwdata;

   logic [511:0] regs1, regs0;
   logic [15:0]  pulse1, pulse0;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mdl [2][16];

   apb_completer_regs_if #(.dataWidth(32), .addrWidth(32)) if1 ();
   apb_completer_regs_if #(.dataWidth(32), .addrWidth(32)) if0 ();

   assign if1.pselx = psel[1];
   assign if0.pselx = psel[0];
   assign if1.penable = penable;
   assign if0.penable = penable;
   assign if1.pwrite = pwrite;
   assign if0.pwrite = pwrite;
   assign if1.pprot = pprot;
   assign if0.pprot = pprot;
   assign if1.pstrb = pstrb;
   assign if0.pstrb = pstrb;
   assign if1.paddr = paddr;
   assign if0.paddr = paddr;
   assign if1.pwdata = pwdata;
   assign if0.pwdata = pwdata;

   apb_completer_regs #(.dataWidth(32), .addrWidth(32), .NUM_REGS(16),
                        .WAIT_CYCLES(1), .ID_VALUE(ID)) dut1 (
      .clk(clk), .rst(rst1), .bus(if1), .regs_o(regs1), .wr_pulse_o(pulse1));

   apb_completer_regs #(.dataWidth(32), .addrWidth(32), .NUM_REGS(16),
                        .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
      .clk(clk), .rst(rst0), .bus(if0), .regs_o(regs0), .wr_pulse_o(pulse0));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [2:0]  prot;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [15:0] exp_pulse;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 1) ? if1.pready : if0.pready;
   endfunction

   task automatic model_reset(input int d);
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
   endtask

   // Reference: the register map rules expressed as plain arithmetic.
   task automatic model(input int d, input logic wr, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [2:0] prot, output logic err,
                        output logic [31:0] rd, output logic [15:0] pulse);
      int idx;
      idx = int'(addr / 4);
      err = (addr % 4 != 0) || (idx >= 16) || (wr && idx == 0) ||
            (wr && !prot[0] && idx >= 8);
      rd = 32'h0;
      pulse = 16'h0;
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
            pulse[idx] = 1'b1;
         end else begin
            rd = (idx == 0) ? ID : mdl[d][idx];
         end
      end
   endtask

   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wdata,
                       input logic [2:0] prot, output int lat, output logic err,
                       output logic [31:0] rd, output logic [15:0] pulse);
      psel = 2'b00;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pstrb = strb;
      pwdata = wdata;
      pprot = prot;
      @(posedge clk); #1;
      penable = 1'b1;
      pwdata = ~wdata;
      lat = 1;
      err = 1'b0;
      rd = 32'h0;
      @(negedge clk);
      while (!rdy(d) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         @(negedge clk);
      end
      if (rdy(d)) begin
         err = (d == 1) ? if1.pslverr : if0.pslverr;
         rd  = (d == 1) ? if1.prdata : if0.prdata;
      end
      @(posedge clk); #1;
      pulse = (d == 1) ? pulse1 : pulse0;
      psel = 2'b00;
      penable = 1'b0;
   endtask

   task automatic run_model_xfer(input int d, input string tag, input logic wr,
                                 input logic [31:0] addr, input logic [3:0] strb,
                                 input logic [31:0] wdata, input logic [2:0] prot);
      logic e_err, a_err;
      logic [31:0] e_rd, a_rd;
      logic [15:0] e_pulse, a_pulse;
      int lat;
      model(d, wr, addr, strb, wdata, prot, e_err, e_rd, e_pulse);
      xfer(d, wr, addr, strb, wdata, prot, lat, a_err, a_rd, a_pulse);
      chk({tag, "_lat"}, 64'(lat), (d == 1) ? 64'd2 : 64'd1);
      chk({tag, "_err"}, 64'(a_err), 64'(e_err));
      chk({tag, "_rd"}, 64'(a_rd), 64'(e_rd));
      chk({tag, "_pulse"}, 64'(a_pulse), 64'(e_pulse));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic e_err, a_err;
      logic [31:0] e_rd, a_rd;
      logic [15:0] e_pulse, a_pulse;
      int lat;
      logic wr;
      logic [31:0] addr;

      rst1 = 1'b0; rst0 = 1'b0;
      psel = 2'b00; penable = 1'b0; pwrite = 1'b0; pprot = 3'b000;
      pstrb = 4'h0; paddr = 32'h0; pwdata = 32'h0;
      model_reset(0); model_reset(1);

      tbl.push_back('{1'b0, 32'h00, 4'hF, 32'h0,        3'b000, 1'b0, ID,           16'h0000});
      tbl.push_back('{1'b1, 32'h04, 4'h5, 32'hDEADBEEF, 3'b000, 1'b0, 32'h0,        16'h0002});
      tbl.push_back('{1'b0, 32'h04, 4'hF, 32'h0,        3'b000, 1'b0, 32'h00AD00EF, 16'h0000});
      tbl.push_back('{1'b1, 32'h02, 4'hF, 32'h11111111, 3'b001, 1'b1, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 32'h40, 4'hF, 32'h11111111, 3'b001, 1'b1, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 32'h00, 4'hF, 32'h11111111, 3'b001, 1'b1, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 32'h20, 4'hF, 32'h22222222, 3'b000, 1'b1, 32'h0,        16'h0000});
      tbl.push_back('{1'b0, 32'h20, 4'hF, 32'h0,        3'b000, 1'b0, 32'h0,        16'h0000});
      tbl.push_back('{1'b0, 32'h00, 4'hF, 32'h0,        3'b000, 1'b0, ID,           16'h0000});
      tbl.push_back('{1'b0, 32'h04, 4'hF, 32'h0,        3'b000, 1'b0, 32'h00AD00EF, 16'h0000});
      tbl.push_back('{1'b1, 32'h20, 4'hF, 32'h12345678, 3'b001, 1'b0, 32'h0,        16'h0100});
      tbl.push_back('{1'b0, 32'h20, 4'h0, 32'h0,        3'b000, 1'b0, 32'h12345678, 16'h0000});
      tbl.push_back('{1'b0, 32'h42, 4'hF, 32'h0,        3'b001, 1'b1, 32'h0,        16'h0000});
      tbl.push_back('{1'b0, 32'h40, 4'hF, 32'h0,        3'b001, 1'b1, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 32'h1C, 4'h0, 32'hFFFFFFFF, 3'b000, 1'b0, 32'h0,        16'h0080});
      tbl.push_back('{1'b0, 32'h1C, 4'hF, 32'h0,        3'b000, 1'b0, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 32'h3C, 4'h8, 32'hCAFEF00D, 3'b001, 1'b0, 32'h0,        16'h8000});
      tbl.push_back('{1'b0, 32'h3C, 4'hF, 32'h0,        3'b000, 1'b0, 32'hCA000000, 16'h0000});

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready", 64'(if1.pready), 64'd0);
      chk("rst_pslverr", 64'(if1.pslverr), 64'd0);
      chk("rst_prdata", 64'(if1.prdata), 64'd0);
      chk("rst_pulse", 64'(pulse1), 64'd0);
      chk("rst_reg0", 64'(regs1[31:0]), 64'(ID));
      chk("rst_regs_hi", 64'(|regs1[511:32]), 64'd0);
      rst1 = 1'b1; rst0 = 1'b1;
      @(posedge clk); #1;

      // Access phase without setup must be ignored.
      psel = 2'b10; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4;
      pstrb = 4'hF; pwdata = 32'hFFFFFFFF; pprot = 3'b001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("noset_pready%0d", c), 64'(if1.pready), 64'd0);
         @(posedge clk); #1;
      end
      chk("noset_pulse", 64'(pulse1), 64'd0);
      chk("noset_reg1", 64'(regs1[63:32]), 64'd0);
      psel = 2'b00; penable = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         xfer(1, tbl[i].wr, tbl[i].addr, tbl[i].strb, tbl[i].wdata, tbl[i].prot,
              lat, a_err, a_rd, a_pulse);
         model(1, tbl[i].wr, tbl[i].addr, tbl[i].strb, tbl[i].wdata, tbl[i].prot,
               e_err, e_rd, e_pulse);
         chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd2);
         chk($sformatf("tbl%0d_err", i), 64'(a_err), 64'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_rd", i), 64'(a_rd), 64'(tbl[i].exp_rd));
         chk($sformatf("tbl%0d_pulse", i), 64'(a_pulse), 64'(tbl[i].exp_pulse));
      end
      chk("tbl_reg8", 64'(regs1[8*32 +: 32]), 64'h12345678);

      // Master abort after one wait cycle of a write to register 3.
      psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
      pstrb = 4'hF; pwdata = 32'hAAAAAAAA; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk("abort_wait_pready", 64'(if1.pready), 64'd0);
      @(posedge clk); #1;
      psel = 2'b00; penable = 1'b0;
      @(negedge clk);
      chk("abort_pready", 64'(if1.pready), 64'd0);
      @(posedge clk); #1;
      chk("abort_pulse", 64'(pulse1), 64'd0);
      chk("abort_reg3", 64'(regs1[3*32 +: 32]), 64'd0);
      @(posedge clk); #1;
      chk("abort_pulse2", 64'(pulse1), 64'd0);
      run_model_xfer(1, "abort_rd", 1'b0, 32'hC, 4'hF, 32'h0, 3'b000);

      // Reset during the wait phase of a write to register 1.
      psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4;
      pstrb = 4'hF; pwdata = 32'h55555555; pprot = 3'b001;
      @(posedge clk); #1;
      penable = 1'b1;
      #2;
      rst1 = 1'b0;
      #1;
      chk("rstmid_pready", 64'(if1.pready), 64'd0);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid_pready2", 64'(if1.pready), 64'd0);
      chk("rstmid_reg1", 64'(regs1[63:32]), 64'd0);
      chk("rstmid_pulse", 64'(pulse1), 64'd0);
      @(posedge clk); #1;
      psel = 2'b00; penable = 1'b0;
      rst1 = 1'b1;
      model_reset(1);
      @(posedge clk); #1;
      run_model_xfer(1, "rstmid_id", 1'b0, 32'h0, 4'hF, 32'h0, 3'b000);
      run_model_xfer(1, "rstmid_rd1", 1'b0, 32'h4, 4'hF, 32'h0, 3'b000);
      run_model_xfer(1, "rstmid_wr1", 1'b1, 32'h4, 4'hF, 32'h0BADF00D, 3'b001);
      run_model_xfer(1, "rstmid_rb1", 1'b0, 32'h4, 4'hF, 32'h0, 3'b000);

      for (int i = 0; i < 300; i++) begin
         wr = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 17)) * 32'd4;
         if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
         run_model_xfer(1, $sformatf("rnd1_%0d", i), wr, addr, 4'($urandom),
                        $urandom, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      // Zero wait states: back-to-back write then read of register 2.
      run_model_xfer(0, "b2b_wr", 1'b1, 32'h8, 4'hF, 32'h13579BDF, 3'b000);
      run_model_xfer(0, "b2b_rd", 1'b0, 32'h8, 4'hF, 32'h0, 3'b000);
      chk("b2b_model", 64'(mdl[0][2]), 64'h13579BDF);

      for (int i = 0; i < 100; i++) begin
         wr = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 17)) * 32'd4;
         if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
         run_model_xfer(0, $sformatf("rnd0_%0d", i), wr, addr, 4'($urandom),
                        $urandom, 3'($urandom_range(0, 7)));
      end

      chk("end_reg0_d1", 64'(regs1[31:0]), 64'(ID));
      chk("end_reg0_d0", 64'(regs0[31:0]), 64'(ID));
      for (int r = 1; r < 16; r++) begin
         chk($sformatf("end_d1_reg%0d", r), 64'(regs1[r*32 +: 32]), 64'(mdl[1][r]));
         chk($sformatf("end_d0_reg%0d", r), 64'(regs0[r*32 +: 32]), 64'(mdl[0][r]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
